// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//
// Shared definitions for the pipeline hazard / forwarding controller.
//
// Contents:
//   REG_AW        - register-ID width (32 architectural registers, x0 = zero)
//   FWD_RF/MEM/WB - EX operand source encoding driven on fwd_a_sel/fwd_b_sel
//   stage_slot_t  - shadow of one in-flight instruction's write-back intent
//   SLOT_EMPTY    - the bubble value of a slot
//   slot_writes() - "slot writes register r" predicate (x0 never matches)
//   fwd_select()  - operand source for one ID source register
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              is_load;
    } stage_slot_t;

    localparam stage_slot_t SLOT_EMPTY = '0;

    // x0 is hardwired to zero, so a write to it is never a real producer.
    function automatic logic slot_writes(input stage_slot_t s,
                                         input logic [REG_AW-1:0] r);
        return s.valid & s.we & (s.rd == r) & (r != '0);
    endfunction

    // Source for one ID operand once the ID instruction has moved into EX.
    // The instruction now in EX will be in MEM then (FWD_MEM); the one now in
    // MEM will be in WB (FWD_WB). The younger producer is checked first so it
    // wins when both write the same register.
    function automatic logic [1:0] fwd_select(input logic              use_rs,
                                              input logic [REG_AW-1:0] rs,
                                              input stage_slot_t       ex,
                                              input stage_slot_t       mem);
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_rs) begin
            if (slot_writes(ex, rs)) begin
                sel = FWD_MEM;
            end else if (slot_writes(mem, rs)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage : pipe_pkg

// File: rtl/reg_hazard_slot.sv
// ---------------------------------------------------------------------------
// reg_hazard_slot
//
// One pipeline shadow slot. Each cycle the slot either holds its contents,
// takes a bubble, or loads the value presented by the previous stage.
// hold has priority over bubble.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-low reset (slot becomes empty)
//   hold    in   keep current contents (pipeline frozen)
//   bubble  in   load an empty slot instead of d
//   d       in   slot value from the previous stage
//   q       out  current slot contents
// ---------------------------------------------------------------------------
module reg_hazard_slot
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        bubble,
    input  stage_slot_t d,
    output stage_slot_t q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= SLOT_EMPTY;
        end else if (!hold) begin
            if (bubble) begin
                q <= SLOT_EMPTY;
            end else begin
                q <= d;
            end
        end
    end

endmodule : reg_hazard_slot

// File: rtl/reg_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// reg_hazard_ctrl
//
// Hazard and forwarding controller for a 5-stage (IF/ID/EX/MEM/WB) pipeline
// with a 32-entry integer register file. Shadows the destination of each
// instruction in EX, MEM and WB, stalls IF/ID for one cycle on a load-use
// hazard (inserting an EX bubble), produces registered EX operand-forwarding
// selects and counts load-use stall cycles with a saturating counter.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   id_valid     in   valid instruction in ID
//   id_rs1_id    in   ID source register 1
//   id_rs2_id    in   ID source register 2
//   id_use_rs1   in   ID instruction reads rs1
//   id_use_rs2   in   ID instruction reads rs2
//   id_rd_id     in   ID destination register
//   id_we        in   ID instruction writes rd
//   id_is_load   in   ID instruction is a load (data ready at end of MEM)
//   flush        in   taken branch/jump resolved in EX, kills ID instruction
//   mem_hold     in   data memory busy, freezes the whole pipeline
//   stall        out  hold PC and IF/ID (combinational)
//   ex_valid     out  EX slot holds a real instruction (registered)
//   fwd_a_sel    out  EX operand A source: 0 regfile, 1 MEM, 2 WB (registered)
//   fwd_b_sel    out  EX operand B source, same encoding (registered)
//   stall_cnt    out  saturating count of load-use stall cycles (registered)
//
// ID handshake: id_valid qualifies the ID fields. While stall is 1 the ID
// instruction is not consumed; IF/ID keeps presenting the same instruction
// and it is re-evaluated in the following cycle.
// ---------------------------------------------------------------------------
module reg_hazard_ctrl #(
    parameter int REG_AW    = pipe_pkg::REG_AW,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_AW-1:0]    id_rs1_id,
    input  logic [REG_AW-1:0]    id_rs2_id,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_AW-1:0]    id_rd_id,
    input  logic                 id_we,
    input  logic                 id_is_load,
    input  logic                 flush,
    input  logic                 mem_hold,
    output logic                 stall,
    output logic                 ex_valid,
    output logic [1:0]           fwd_a_sel,
    output logic [1:0]           fwd_b_sel,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    pipe_pkg::stage_slot_t id_slot;
    pipe_pkg::stage_slot_t ex_q;
    pipe_pkg::stage_slot_t mem_q;
    pipe_pkg::stage_slot_t wb_q;

    logic       rs1_hit;
    logic       rs2_hit;
    logic       load_use;
    logic       kill_id;
    logic [1:0] fwd_a_next;
    logic [1:0] fwd_b_next;

    // -----------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------
    always_comb begin
        id_slot         = pipe_pkg::SLOT_EMPTY;
        id_slot.valid   = id_valid;
        id_slot.rd      = id_rd_id;
        id_slot.we      = id_we;
        id_slot.is_load = id_is_load;
    end

    assign rs1_hit = id_use_rs1 & (id_rs1_id == ex_q.rd);
    assign rs2_hit = id_use_rs2 & (id_rs2_id == ex_q.rd);

    // A load in EX only has its data at the end of MEM, one cycle too late
    // for a dependent instruction entering EX next cycle.
    assign load_use = id_valid & ex_q.valid & ex_q.is_load & ex_q.we
                    & (ex_q.rd != '0) & (rs1_hit | rs2_hit);

    // Either condition turns the incoming EX slot into a bubble.
    assign kill_id = flush | load_use;

    // A flushed ID instruction is dead, so it need not be held. The rst term
    // keeps stall low while in reset even if mem_hold is asserted.
    assign stall = rst & (mem_hold | (load_use & ~flush));

    // -----------------------------------------------------------------------
    // Shadow slots: EX loads from ID, MEM from EX, WB from MEM.
    // -----------------------------------------------------------------------
    reg_hazard_slot u_ex_slot (
        .clk    (clk),
        .rst    (rst),
        .hold   (mem_hold),
        .bubble (kill_id),
        .d      (id_slot),
        .q      (ex_q)
    );

    reg_hazard_slot u_mem_slot (
        .clk    (clk),
        .rst    (rst),
        .hold   (mem_hold),
        .bubble (1'b0),
        .d      (ex_q),
        .q      (mem_q)
    );

    reg_hazard_slot u_wb_slot (
        .clk    (clk),
        .rst    (rst),
        .hold   (mem_hold),
        .bubble (1'b0),
        .d      (mem_q),
        .q      (wb_q)
    );

    // The WB slot is a shadow only: a producer in WB is covered by the
    // regfile's write-through, so nothing forwards from it.
    logic unused_wb;
    assign unused_wb = &{1'b0, wb_q};

    assign ex_valid = ex_q.valid;

    // -----------------------------------------------------------------------
    // Forwarding selects, from the pre-update EX/MEM slots
    // -----------------------------------------------------------------------
    assign fwd_a_next = pipe_pkg::fwd_select(id_use_rs1, id_rs1_id, ex_q, mem_q);
    assign fwd_b_next = pipe_pkg::fwd_select(id_use_rs2, id_rs2_id, ex_q, mem_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_a_sel <= pipe_pkg::FWD_RF;
            fwd_b_sel <= pipe_pkg::FWD_RF;
        end else if (!mem_hold) begin
            if (kill_id) begin
                fwd_a_sel <= pipe_pkg::FWD_RF;
                fwd_b_sel <= pipe_pkg::FWD_RF;
            end else begin
                fwd_a_sel <= fwd_a_next;
                fwd_b_sel <= fwd_b_next;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Load-use stall counter. A flush in the same cycle wins over the hazard,
    // so that cycle is not a stall and is not counted.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!mem_hold && !flush && load_use && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule : reg_hazard_ctrl
